// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader is the slave on the stream and drives the memory write side.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed big-endian byte image into instruction memory from
// word 0 upward, holding the core in reset until the whole image is written.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_run,
    output logic                done,
    output logic                error
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;

    localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

    state_t          state;
    logic [7:0]      len_hi;
    logic [15:0]     len;
    logic [ADDR_W:0] word_cnt;
    logic [1:0]      byte_idx;
    logic [23:0]     word_buf;
    logic            fire;
    logic [15:0]     hdr_n;
    logic            last_word;

    assign bus.byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign fire           = bus.byte_valid && bus.byte_ready;
    assign hdr_n          = {len_hi, bus.byte_data};
    assign last_word      = (17'(word_cnt) + 17'd1) == {1'b0, len};

    // Datapath holding registers; only ever loaded while a byte is accepted.
    always_ff @(posedge clock) begin
        if (fire) begin
            case (state)
                LEN_HI:  len_hi   <= bus.byte_data;
                LEN_LO:  len      <= hdr_n;
                DATA:    word_buf <= {word_buf[15:0], bus.byte_data};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            word_cnt       <= '0;
            byte_idx       <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_run        <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= LEN_HI;
                end
                LEN_HI: begin
                    if (fire) state <= LEN_LO;
                end
                LEN_LO: begin
                    if (fire) begin
                        word_cnt <= '0;
                        byte_idx <= '0;
                        if (hdr_n == 16'd0 || {1'b0, hdr_n} > CAP) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (fire) begin
                        byte_idx <= byte_idx + 2'd1;
                        // Word completes on this edge; the write lands next cycle so bytes never stall.
                        if (byte_idx == 2'd3) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= word_cnt[ADDR_W-1:0];
                            bus.imem_wdata <= {word_buf, bus.byte_data};
                            word_cnt       <= word_cnt + 1'b1;
                            if (last_word) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                cpu_run <= 1'b1;
                            end
                        end
                    end
                end
                DONE, ERR: begin
                    if (start) begin
                        state   <= LEN_HI;
                        done    <= 1'b0;
                        cpu_run <= 1'b0;
                        error   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised bench for imem_boot_loader: a write scoreboard built from the
// image being sent is checked against every imem_we strobe.
module tb_imem_boot_loader;
    localparam int ADDR_W = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic cpu_run, done, error;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .bus     (bus.slave),
        .cpu_run (cpu_run),
        .done    (done),
        .error   (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        bit                last;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               e;
    logic [ADDR_W-1:0] seen_addr[$];
    logic [31:0]       seen_data[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endfunction

    always @(posedge clock) cyc++;

    // Every write strobe must match the next expected word of the image.
    always @(negedge clock) begin
        if (reset_n && bus.imem_we) begin
            seen_addr.push_back(bus.imem_addr);
            seen_data.push_back(bus.imem_wdata);
            if (exp_q.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("we_addr", bus.imem_addr, e.addr);
                check("we_data", bus.imem_wdata, e.data);
                check("done_at_write", done, e.last);
                check("cpu_run_at_write", cpu_run, e.last);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            bus.byte_valid = 1'b0;
            @(posedge clock); #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!acc && guard < 64) begin
            @(negedge clock);
            acc = bus.byte_ready;
            @(posedge clock); #1;
            guard++;
        end
        if (!acc) check("byte_accept_timeout", 0, 1);
        bus.byte_valid = 1'b0;
    endtask

    task automatic load_words(input logic [31:0] words[$], input int gap, input bit stray);
        logic [15:0] n;
        logic [31:0] w;
        n = 16'(words.size());
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            exp_q.push_back('{addr: ADDR_W'(i), data: w, last: bit'(i == words.size() - 1)});
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[8*k +: 8], gap);
                if (stray && i == 0 && k == 2) pulse_start();
            end
        end
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (!done && g < 8) begin
            @(posedge clock); #1;
            g++;
        end
        check("done", done, 1);
        check("cpu_run", cpu_run, 1);
        check("error_clear", error, 0);
        check("byte_ready_done", bus.byte_ready, 0);
        @(posedge clock); #1;
        check("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] img[$];
        logic [15:0] n;
        logic [31:0] w;
        int t0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        #3;
        check("reset_outputs", {bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                                cpu_run, done, error}, 0);
        #9 reset_n = 1'b1;
        @(posedge clock); #1;

        // Reference image, back to back.
        pulse_start();
        img = '{32'h20080005, 32'hAC010000};
        seen_addr.delete(); seen_data.delete();
        t0 = cyc;
        load_words(img, 0, 1'b0);
        check("burst_cycles", cyc - t0, 10);
        wait_done();
        check("lit_count", seen_addr.size(), 2);
        check("lit_w0", seen_data[0], 32'h20080005);
        check("lit_a1", seen_addr[1], 1);
        check("lit_w1", seen_data[1], 32'hAC010000);

        // Restart from DONE, same image with byte_valid toggling.
        pulse_start();
        check("restart_cpu_run", cpu_run, 0);
        check("restart_done", done, 0);
        check("restart_ready", bus.byte_ready, 1);
        seen_addr.delete(); seen_data.delete();
        load_words(img, 100, 1'b0);
        wait_done();
        check("toggle_w0", seen_data[0], 32'h20080005);
        check("toggle_w1", seen_data[1], 32'hAC010000);

        // Zero-length header.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clock);
        check("err0_error", error, 1);
        check("err0_ready", bus.byte_ready, 0);
        check("err0_cpu_run", cpu_run, 0);
        check("err0_done", done, 0);
        repeat (3) @(posedge clock);
        #1;

        // Oversized header.
        pulse_start();
        check("err_cleared", error, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clock);
        check("err257_error", error, 1);
        check("err257_ready", bus.byte_ready, 0);
        @(posedge clock); #1;

        // Full-capacity image with a stray start during DATA.
        pulse_start();
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back($urandom);
        seen_addr.delete(); seen_data.delete();
        load_words(img, 0, 1'b1);
        wait_done();
        check("full_count", seen_addr.size(), 256);
        check("full_last_addr", seen_addr[255], 8'hFF);

        // Reset part way through word 1.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        w = 32'hDEADBEEF;
        exp_q.push_back('{addr: '0, data: w, last: 1'b0});
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        #2 reset_n = 1'b0;
        #1;
        check("midload_reset_outputs", {bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                                        cpu_run, done, error}, 0);
        @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("abort_no_pending", exp_q.size(), 0);
        check("abort_cpu_run", cpu_run, 0);
        check("abort_ready", bus.byte_ready, 0);

        // Random images with random gaps.
        for (int r = 0; r < 6; r++) begin
            pulse_start();
            img.delete();
            n = 16'($urandom_range(24, 1));
            for (int i = 0; i < int'(n); i++) img.push_back($urandom);
            load_words(img, int'($urandom_range(60)), bit'($urandom_range(1)));
            wait_done();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
